// File: rtl/accumulator_bank_pkg.sv
// accumulator_bank_pkg: shared FSM state, bfp32 word type and constants for the accumulator bank.
package accumulator_bank_pkg;

    typedef enum logic [1:0] {IDLE, REDUCE, WRITE} state_t;

    typedef logic [31:0] bfp32_t;

    localparam bfp32_t BFP32_ZERO = 32'h0000_0000;
    localparam bfp32_t BFP32_QNAN = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit aligned mantissa; 27 when the input is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] z;
        z = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) z = 5'(26 - i);
        return z;
    endfunction

endpackage

// File: rtl/accumulator_bank_bfp32_adder.sv
// bfp32_adder: combinational IEEE-754 single-precision adder, round-to-nearest-even.
module bfp32_adder
    import accumulator_bank_pkg::*;
(
    input  bfp32_t a,
    input  bfp32_t b,
    output bfp32_t o
);

    bfp32_t      x, y;
    logic [7:0]  ex, ey, d;
    logic [4:0]  dc, lz, sh;
    logic [55:0] ys;
    logic [26:0] xa, ya, n;
    logic [27:0] s;
    logic [9:0]  e;
    logic [30:0] r;
    logic        up;

    // x is the larger magnitude, so the result takes its sign and exponent as reference.
    always_comb begin
        x  = b[30:0] > a[30:0] ? b : a;
        y  = b[30:0] > a[30:0] ? a : b;
        ex = x[30:23] == 8'd0 ? 8'd1 : x[30:23];
        ey = y[30:23] == 8'd0 ? 8'd1 : y[30:23];
        d  = ex - ey;
        dc = d > 8'd31 ? 5'd31 : d[4:0];
        ys = {y[30:23] != 8'd0, y[22:0], 32'd0} >> dc;
        xa = {x[30:23] != 8'd0, x[22:0], 3'd0};
        ya = {ys[55:30], |ys[29:0]};
        s  = x[31] == y[31] ? {1'b0, xa} + {1'b0, ya} : {1'b0, xa} - {1'b0, ya};
        lz = lzc27(s[26:0]);
        sh = {3'd0, lz} < ex ? lz : 5'(ex - 8'd1);
        n  = s[27] ? {s[27:2], |s[1:0]} : s[26:0] << sh;
        e  = s[27] ? {2'd0, ex} + 10'd1 : {2'd0, ex} - {5'd0, sh};
        up = n[2] & (n[3] | n[1] | n[0]);
        r  = {n[26] ? e[7:0] : 8'd0, n[25:3]} + {30'd0, up};
        o  = e >= 10'd255 ? {x[31], 8'hFF, 23'd0} : {x[31], r};
        if (s == 28'd0)
            o = {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'hFF)
            o = (x[22:0] != 23'd0 || (y[30:0] == x[30:0] && x[31] != y[31])) ? BFP32_QNAN : x;
    end

endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: ARR_SIZE bfp32 column accumulators with serial reduction and buffered write-out.
// Per-column readout (readout_mode = 1) exists only when ACC_COLUMN_READOUT_EN is defined.
module accumulator_bank
    import accumulator_bank_pkg::*;
#(
    parameter int ARR_SIZE    = 4,
    parameter int VERTICAL_BW = 32,
    parameter int ADDR_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0] accumulated_val,
    input  logic                          acc_reset,
    input  logic                          store_output,
    input  logic                          readout_mode,
    input  logic [ADDR_W-1:0]             op_buffer_address,
    output logic [31:0]                   output_data,
    output logic [ADDR_W-1:0]             output_buffer_addr,
    output logic                          output_buffer_enable,
    output logic                          busy,
    output logic                          drop_flag
);

    localparam int IW = ARR_SIZE > 1 ? $clog2(ARR_SIZE) : 1;

    state_t            state, state_nxt;
    bfp32_t            acc     [ARR_SIZE];
    bfp32_t            acc_nxt [ARR_SIZE];
    bfp32_t            sum, sum_nxt, word, last_data;
    logic [IW-1:0]     idx;
    logic [ADDR_W-1:0] base, addr, last_addr;
    logic              last, start, col_mode, wr_done;

    for (genvar k = 0; k < ARR_SIZE; k++) begin : g_col
        bfp32_adder u_add (
            .a(acc[k]),
            .b(accumulated_val[k*VERTICAL_BW +: VERTICAL_BW]),
            .o(acc_nxt[k])
        );
    end

    bfp32_adder u_reduce (
        .a(sum),
        .b(acc[idx]),
        .o(sum_nxt)
    );

`ifdef ACC_COLUMN_READOUT_EN
    logic mode;
    always_ff @(posedge clk) begin
        if (rst || acc_reset)
            mode <= 1'b0;
        else if (start)
            mode <= readout_mode;
    end
    assign col_mode = readout_mode;
    assign wr_done  = !mode || last;
    assign word     = mode ? acc[idx] : sum;
`else
    logic unused_mode;
    assign unused_mode = readout_mode;
    assign col_mode    = 1'b0;
    assign wr_done     = 1'b1;
    assign word        = sum;
`endif

    assign last  = idx == IW'(ARR_SIZE - 1);
    assign start = state == IDLE && store_output;
    assign addr  = base + ADDR_W'(idx);

    always_comb begin
        state_nxt = state == IDLE   ? (store_output ? (col_mode ? WRITE : REDUCE) : IDLE) :
                    state == REDUCE ? (last ? WRITE : REDUCE) :
                                      (wr_done ? IDLE : WRITE);
    end

    // idx walks the columns in REDUCE and the output words in WRITE; it rests at 0 in IDLE.
    always_ff @(posedge clk) begin
        if (rst || acc_reset) begin
            state     <= IDLE;
            sum       <= BFP32_ZERO;
            idx       <= '0;
            drop_flag <= 1'b0;
            for (int i = 0; i < ARR_SIZE; i++)
                acc[i] <= BFP32_ZERO;
        end else begin
            state     <= state_nxt;
            idx       <= (state != IDLE && !last) ? idx + 1'b1 : '0;
            sum       <= state == REDUCE ? sum_nxt : start ? BFP32_ZERO : sum;
            drop_flag <= drop_flag | (busy & in_valid);
            if (state == IDLE && in_valid)
                acc <= acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= '0;
            last_data <= BFP32_ZERO;
            last_addr <= '0;
        end else begin
            if (start)
                base <= op_buffer_address;
            if (output_buffer_enable) begin
                last_data <= word;
                last_addr <= addr;
            end
        end
    end

    assign output_buffer_enable = state == WRITE;
    assign busy                 = state != IDLE;
    assign output_data          = output_buffer_enable ? word : last_data;
    assign output_buffer_addr   = output_buffer_enable ? addr : last_addr;

endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: directed self-checking bench for accumulator_bank (default or ACC_COLUMN_READOUT_EN build).
module tb_accumulator_bank;

    localparam int N  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, acc_reset, store_output, readout_mode;
    logic [N*32-1:0] accumulated_val;
    logic [AW-1:0] op_buffer_address, output_buffer_addr;
    logic [31:0]   output_data;
    logic          output_buffer_enable, busy, drop_flag;
    int            passed = 0;
    int            total  = 0;

    always #5 clk = ~clk;

    accumulator_bank #(.ARR_SIZE(N), .VERTICAL_BW(32), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .accumulated_val(accumulated_val),
        .acc_reset(acc_reset),
        .store_output(store_output),
        .readout_mode(readout_mode),
        .op_buffer_address(op_buffer_address),
        .output_data(output_data),
        .output_buffer_addr(output_buffer_addr),
        .output_buffer_enable(output_buffer_enable),
        .busy(busy),
        .drop_flag(drop_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic feed(input logic [31:0] c0, c1, c2, c3, input int cycles);
        accumulated_val = {c3, c2, c1, c0};
        in_valid = 1'b1;
        repeat (cycles) tick();
        in_valid = 1'b0;
    endtask

    task automatic clear();
        acc_reset = 1'b1;
        tick();
        acc_reset = 1'b0;
    endtask

    task automatic store(input string tag, input logic mode, input logic [AW-1:0] a,
                         input int lat, input logic [31:0] exp_data);
        int n;
        store_output = 1'b1;
        readout_mode = mode;
        op_buffer_address = a;
        tick();
        store_output = 1'b0;
        n = 1;
        while (!output_buffer_enable && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " addr"}, {28'd0, output_buffer_addr}, {28'd0, a});
        chk({tag, " data"}, output_data, exp_data);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int strobes;
        strobes = 0;
        repeat (cycles) begin
            tick();
            if (output_buffer_enable) strobes++;
        end
        chk({tag, " strobes"}, strobes, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        acc_reset = 1'b0;
        store_output = 1'b0;
        readout_mode = 1'b0;
        op_buffer_address = '0;
        accumulated_val = '0;
        repeat (2) tick();
        chk("rst data", output_data, 32'h0);
        chk("rst addr", {28'd0, output_buffer_addr}, 32'h0);
        chk("rst enable", {31'd0, output_buffer_enable}, 32'h0);
        chk("rst busy", {31'd0, busy}, 32'h0);
        chk("rst drop", {31'd0, drop_flag}, 32'h0);
        rst = 1'b0;
        tick();

        feed(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1);
        store("sum4", 1'b0, 4'd3, 5, 32'h40800000);
        tick();
        chk("sum4 enable off", {31'd0, output_buffer_enable}, 32'h0);
        chk("sum4 hold data", output_data, 32'h40800000);
        chk("sum4 hold addr", {28'd0, output_buffer_addr}, 32'd3);
        chk("sum4 idle", {31'd0, busy}, 32'h0);

        clear();
        feed(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 3);
        store("sum30", 1'b0, 4'd5, 5, 32'h41F00000);
        tick();

        clear();
        feed(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 1);
`ifdef ACC_COLUMN_READOUT_EN
        store("col0", 1'b1, 4'd14, 1, 32'h3F800000);
        tick();
        chk("col1 enable", {31'd0, output_buffer_enable}, 32'h1);
        chk("col1 addr", {28'd0, output_buffer_addr}, 32'd15);
        chk("col1 data", output_data, 32'h40000000);
        tick();
        chk("col2 addr", {28'd0, output_buffer_addr}, 32'd0);
        chk("col2 data", output_data, 32'h40400000);
        tick();
        chk("col3 addr", {28'd0, output_buffer_addr}, 32'd1);
        chk("col3 data", output_data, 32'h40800000);
        tick();
        chk("col done enable", {31'd0, output_buffer_enable}, 32'h0);
        chk("col done busy", {31'd0, busy}, 32'h0);
`else
        store("mode ignored", 1'b1, 4'd14, 5, 32'h41200000);
        tick();
        chk("mode ignored single", {31'd0, output_buffer_enable}, 32'h0);
`endif
        store("retained", 1'b0, 4'd9, 5, 32'h41200000);
        tick();

        clear();
        accumulated_val = {4{32'h3F800000}};
        in_valid = 1'b1;
        store_output = 1'b1;
        readout_mode = 1'b0;
        op_buffer_address = 4'd2;
        tick();
        store_output = 1'b0;
        chk("same cycle busy", {31'd0, busy}, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("drop set", {31'd0, drop_flag}, 32'h1);
        n = 2;
        while (!output_buffer_enable && n < 20) begin
            tick();
            n++;
        end
        chk("same cycle latency", n, 5);
        chk("same cycle data", output_data, 32'h40800000);
        tick();
        store("after drop", 1'b0, 4'd2, 5, 32'h40800000);
        chk("drop sticky", {31'd0, drop_flag}, 32'h1);
        tick();

        store_output = 1'b1;
        op_buffer_address = 4'd7;
        tick();
        store_output = 1'b0;
        tick();
        acc_reset = 1'b1;
        tick();
        acc_reset = 1'b0;
        chk("abort enable", {31'd0, output_buffer_enable}, 32'h0);
        chk("abort busy", {31'd0, busy}, 32'h0);
        chk("abort drop", {31'd0, drop_flag}, 32'h0);
        quiet("abort", 8);
        store("after clear", 1'b0, 4'd7, 5, 32'h00000000);
        tick();

        clear();
        feed(32'h3F800000, 32'h33800000, 32'h33800000, 32'h3F000000, 1);
        store("rne even", 1'b0, 4'd1, 5, 32'h3FC00000);
        tick();
        clear();
        feed(32'h3F800001, 32'h33800000, 32'h00000000, 32'h00000000, 1);
        store("rne up", 1'b0, 4'd1, 5, 32'h3F800002);
        tick();
        clear();
        feed(32'h3FC00000, 32'hBFC00000, 32'h40400000, 32'hC0000000, 1);
        store("cancel", 1'b0, 4'd4, 5, 32'h3F800000);
        tick();

        store_output = 1'b1;
        tick();
        store_output = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst abort enable", {31'd0, output_buffer_enable}, 32'h0);
        chk("rst abort busy", {31'd0, busy}, 32'h0);
        chk("rst abort data", output_data, 32'h0);
        chk("rst abort addr", {28'd0, output_buffer_addr}, 32'h0);
        quiet("rst abort", 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/accumulator_bank.md
ACCUMULATOR_BANK -- requirements
Module: accumulator_bank

Interface
REQ-001 Parameter ARR_SIZE, default 4, number of columns accumulated.
REQ-002 Parameter VERTICAL_BW, default 32, per-column lane width; fixed at 32 (bfp32).
REQ-003 Parameter ADDR_W, default 4, output buffer address width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  accumulated_val carries a valid column vector this cycle.
REQ-007 accumulated_val  input  ARR_SIZE*VERTICAL_BW  column k in bits [k*VERTICAL_BW +: VERTICAL_BW].
REQ-008 acc_reset  input  1  synchronous clear of all accumulators and flags.
REQ-009 store_output  input  1  single-cycle request to write results out.
REQ-010 readout_mode  input  1  0 = reduced sum, 1 = per-column; sampled with store_output.
REQ-011 op_buffer_address  input  ADDR_W  base write address, sampled with store_output.
REQ-012 output_data  output  32  bfp32 write data.
REQ-013 output_buffer_addr  output  ADDR_W  write address.
REQ-014 output_buffer_enable  output  1  one-cycle write strobe per word.
REQ-015 busy  output  1  high in REDUCE or WRITE.
REQ-016 drop_flag  output  1  sticky: in_valid arrived while busy.

Function
REQ-017 Arithmetic: IEEE-754 single, round-to-nearest-even, via bfp32_adder.
REQ-018 FSM states IDLE, REDUCE, WRITE; reset state IDLE.
REQ-019 IDLE, in_valid=1: acc[k] <= acc[k] + column k, all k, visible next cycle.
REQ-020 IDLE, store_output=1, mode 0: capture address, go REDUCE; sum <= 0, then sum <= sum + acc[i] for i = 0..ARR_SIZE-1, one column per cycle, then WRITE.
REQ-021 Mode 0 WRITE: one cycle, output_data = sum, output_buffer_addr = captured base, enable = 1, then IDLE; store_output-to-enable latency ARR_SIZE+1 cycles.
REQ-022 Mode 1: IDLE to WRITE directly; ARR_SIZE consecutive strobes, word k = acc[k] at base+k modulo 2^ADDR_W; first strobe 1 cycle after store_output.
REQ-023 in_valid and store_output same IDLE cycle: sample accumulated first and included in output.
REQ-024 in_valid while busy: sample discarded, accumulators unchanged, drop_flag <= 1.
REQ-025 store_output while busy: ignored.
REQ-026 Accumulators retained after a store; cleared only by acc_reset or rst.
REQ-027 acc_reset in any state: acc[k], sum, drop_flag <= 0, state <= IDLE, pending write aborted, no strobe; wins over simultaneous in_valid/store_output.
REQ-028 output_data and output_buffer_addr hold last value when enable = 0.

Reset
REQ-029 rst=1 at rising edge: state IDLE, all acc[k] and sum = 0, output_data = 0, output_buffer_addr = 0, output_buffer_enable = 0, busy = 0, drop_flag = 0.
REQ-030 rst mid-REDUCE/WRITE: abort identically to acc_reset, no strobe next cycle.

Configuration
REQ-031 ACC_COLUMN_READOUT_EN defined: readout_mode honoured per REQ-022.
REQ-032 ACC_COLUMN_READOUT_EN undefined: readout_mode ignored, always mode 0; per-column write logic absent.

Structure
REQ-033 Shared package holds FSM state enum, bfp32 word type, bfp32 zero constant.
REQ-034 One sub-module: bfp32_adder (combinational, 32-bit A, B -> O); ARR_SIZE instances for columns, one for reduction.

Verification
REQ-035 rst; in_valid one cycle all columns 0x3F800000 (1.0); store mode 0, addr 3 -> after 5 cycles one strobe, addr 3, data 0x40800000 (4.0).
REQ-036 Three in_valid cycles columns {1.0,2.0,3.0,4.0}; store mode 0 -> data 0x41F00000 (30.0).
REQ-037 Mode 1, addr 14, columns {1.0,2.0,3.0,4.0} once -> strobes at 14,15,0,1 data 0x3F800000, 0x40000000, 0x40400000, 0x40800000.
REQ-038 in_valid with store_output same cycle, columns 1.0 -> sum 4.0; in_valid during REDUCE -> drop_flag = 1, later store unchanged.
REQ-039 acc_reset 2 cycles into REDUCE -> no strobe, busy = 0 next cycle, next store returns 0x00000000.
REQ-040 Build without ACC_COLUMN_READOUT_EN, store readout_mode=1 -> single reduced-sum strobe.
